// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds the {N,Z,C,V} flag register, evaluates the
// instruction condition field and gates side effects of failed instructions.
module cond_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_w_e,
    input  logic             pcs_e,
    input  logic             reg_w_e,
    input  logic             mem_w_e,
    input  logic             no_write_e,
    input  logic             clr_cnt,
    output logic             pc_src_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             cond_ex_e,
    output logic [3:0]       flags_q,
    output logic             carry_in,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam int unsigned FLAG_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Conditions come in complementary pairs; cond_e[0] selects the inverted sense.
    typedef enum logic [2:0] {
        CB_EQ = 3'd0,
        CB_CS = 3'd1,
        CB_MI = 3'd2,
        CB_VS = 3'd3,
        CB_HI = 3'd4,
        CB_GE = 3'd5,
        CB_GT = 3'd6,
        CB_AL = 3'd7
    } cond_base_e;

    logic              n_flag;
    logic              z_flag;
    logic              c_flag;
    logic              v_flag;
    cond_base_e        base_sel;
    logic              base_pass;
    logic              valid;
    logic              upd;
    logic [FLAG_W-1:0] flags_d;
    logic [CNT_W-1:0]  exec_cnt_q;
    logic [CNT_W-1:0]  exec_cnt_d;
    logic [CNT_W-1:0]  skip_cnt_q;
    logic [CNT_W-1:0]  skip_cnt_d;

    assign n_flag   = flags_q[3];
    assign z_flag   = flags_q[2];
    assign c_flag   = flags_q[1];
    assign v_flag   = flags_q[0];
    assign base_sel = cond_base_e'(cond_e[3:1]);

    // Condition evaluation against the pre-edge flag register.
    always_comb begin
        base_pass = 1'b0;
        case (base_sel)
            CB_EQ:   base_pass = z_flag;
            CB_CS:   base_pass = c_flag;
            CB_MI:   base_pass = n_flag;
            CB_VS:   base_pass = v_flag;
            CB_HI:   base_pass = c_flag & ~z_flag;
            CB_GE:   base_pass = (n_flag == v_flag);
            CB_GT:   base_pass = ~z_flag & (n_flag == v_flag);
            CB_AL:   base_pass = 1'b1;
            default: base_pass = 1'b0;
        endcase
        cond_ex_e = (base_sel == CB_AL) ? 1'b1 : (base_pass ^ cond_e[0]);
    end

    assign valid = ~flush_e & ~stall_e;
    assign upd   = valid & cond_ex_e;

    // Side-effect gating; stall is left to the hazard unit.
    assign pc_src_e    = pcs_e & cond_ex_e & ~flush_e;
    assign reg_write_e = reg_w_e & cond_ex_e & ~no_write_e & ~flush_e;
    assign mem_write_e = mem_w_e & cond_ex_e & ~flush_e;

    // N,Z and C,V are written as independent groups.
    always_comb begin
        flags_d = flags_q;
        if (upd && flag_w_e[1]) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (upd && flag_w_e[0]) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    // Saturating instruction counters; clear has priority over increment.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (clr_cnt) begin
            exec_cnt_d = '0;
            skip_cnt_d = '0;
        end else if (valid) begin
            if (cond_ex_e && (exec_cnt_q != CNT_MAX)) begin
                exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end
            if (!cond_ex_e && (skip_cnt_q != CNT_MAX)) begin
                skip_cnt_d = skip_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            flags_q    <= flags_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign carry_in = flags_q[1];
    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;

endmodule
